// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: four EX result channels in, two RF write / ROB done slots out.
// The master modport is the upstream EX/WB side; the slave modport is the arbiter.
interface wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 6
);
    logic [3:0]          ch_vld;
    logic [3:0]          ch_reg_wrt;
    logic [4*PREG_W-1:0] ch_phy_addr;
    logic [4*DATA_W-1:0] ch_data;
    logic [4*ROB_W-1:0]  ch_done_idx;

    logic                wr0_en;
    logic [PREG_W-1:0]   wr0_addr;
    logic [DATA_W-1:0]   wr0_data;
    logic                wr1_en;
    logic [PREG_W-1:0]   wr1_addr;
    logic [DATA_W-1:0]   wr1_data;
    logic                done0_vld;
    logic [ROB_W-1:0]    done0_idx;
    logic                done1_vld;
    logic [ROB_W-1:0]    done1_idx;
    logic                stall_out;

    modport master (
        output ch_vld, ch_reg_wrt, ch_phy_addr, ch_data, ch_done_idx,
        input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        input  done0_vld, done0_idx, done1_vld, done1_idx, stall_out
    );

    modport slave (
        input  ch_vld, ch_reg_wrt, ch_phy_addr, ch_data, ch_done_idx,
        output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        output done0_vld, done0_idx, done1_vld, done1_idx, stall_out
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: 4 result channels -> per-channel FIFOs -> 2 RF write + 2 ROB done slots, round-robin.
// Latency: 1 cycle through the FIFO; 0 extra with WB_BYPASS_EN when an empty-FIFO result is granted directly.
// Backpressure: stall_out when any channel FIFO is full; all inputs are ignored while stalled.
module wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int PREG_W     = 6,
    parameter int ROB_W      = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    wb_arbiter_if.slave  bus
);
    localparam int NCH   = 4;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic              reg_wrt;
        logic [PREG_W-1:0] phy_addr;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  done_idx;
    } entry_t;

    entry_t           mem [NCH][FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr [NCH];
    logic [PTR_W-1:0] wr_ptr [NCH];
    logic [CNT_W-1:0] cnt    [NCH];
    logic [1:0]       rr;
    logic [1:0]       rr_nxt;

    entry_t           in_ent   [NCH];
    entry_t           cand_ent [NCH];
    logic [NCH-1:0]   nonempty;
    logic [NCH-1:0]   full;
    logic [NCH-1:0]   cand;
    logic [NCH-1:0]   grant;
    logic [NCH-1:0]   push;
    logic [NCH-1:0]   pop;
    logic             stall;

    logic             s0_vld;
    logic             s1_vld;
    logic [1:0]       s0_ch;
    logic [1:0]       s1_ch;
    logic [1:0]       scan_ch;

    entry_t           slot_q [2];
    logic [1:0]       slot_vld_q;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            in_ent[i]   = {bus.ch_reg_wrt[i],
                           bus.ch_phy_addr[i*PREG_W +: PREG_W],
                           bus.ch_data[i*DATA_W +: DATA_W],
                           bus.ch_done_idx[i*ROB_W +: ROB_W]};
            nonempty[i] = (cnt[i] != '0);
            full[i]     = (cnt[i] == CNT_W'(FIFO_DEPTH));
            // A granted empty channel can only be a bypass candidate, so take the live input.
            cand_ent[i] = nonempty[i] ? mem[i][rd_ptr[i]] : in_ent[i];
        end
    end

    assign stall = |full;

`ifdef WB_BYPASS_EN
    assign cand = nonempty | (bus.ch_vld & {NCH{~stall & ~flush}});
`else
    assign cand = nonempty;
`endif

    // Round-robin scan from rr; first two candidates fill slot 0 then slot 1.
    always_comb begin
        grant   = '0;
        s0_vld  = 1'b0;
        s1_vld  = 1'b0;
        s0_ch   = '0;
        s1_ch   = '0;
        scan_ch = '0;
        rr_nxt  = rr;
        for (int k = 0; k < NCH; k++) begin
            scan_ch = rr + 2'(k);
            if (cand[scan_ch]) begin
                if (!s0_vld) begin
                    s0_vld         = 1'b1;
                    s0_ch          = scan_ch;
                    grant[scan_ch] = 1'b1;
                    rr_nxt         = scan_ch + 2'd1;
                end else if (!s1_vld) begin
                    s1_vld         = 1'b1;
                    s1_ch          = scan_ch;
                    grant[scan_ch] = 1'b1;
                    rr_nxt         = scan_ch + 2'd1;
                end
            end
        end
    end

    assign pop  = grant & nonempty;
    assign push = bus.ch_vld & ~(grant & ~nonempty) & {NCH{~stall & ~flush}};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NCH; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_ent[i];
        end
    end

    // Flush leaves rr where it was; only queued work is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
        end else if (!flush) begin
            rr <= rr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
            slot_vld_q <= '0;
        end else begin
            slot_q[0]  <= s0_vld ? cand_ent[s0_ch] : '0;
            slot_q[1]  <= s1_vld ? cand_ent[s1_ch] : '0;
            slot_vld_q <= {s1_vld, s0_vld};
        end
    end

    assign bus.wr0_en    = slot_q[0].reg_wrt;
    assign bus.wr0_addr  = slot_q[0].phy_addr;
    assign bus.wr0_data  = slot_q[0].data;
    assign bus.done0_vld = slot_vld_q[0];
    assign bus.done0_idx = slot_q[0].done_idx;
    assign bus.wr1_en    = slot_q[1].reg_wrt;
    assign bus.wr1_addr  = slot_q[1].phy_addr;
    assign bus.wr1_data  = slot_q[1].data;
    assign bus.done1_vld = slot_vld_q[1];
    assign bus.done1_idx = slot_q[1].done_idx;
    assign bus.stall_out = stall;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-channel scoreboard queues checked by a negedge monitor plus directed checks.
// Every stimulus carries its channel number in data[15:12] so the monitor can route outputs.
module tb_wb_arbiter;
    localparam int DATA_W = 16;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 6;
`ifdef WB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    typedef logic [1+PREG_W+DATA_W+ROB_W-1:0] ent_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DATA_W(DATA_W), .PREG_W(PREG_W), .ROB_W(ROB_W)) bus ();

    wb_arbiter #(.DATA_W(DATA_W), .PREG_W(PREG_W), .ROB_W(ROB_W), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    ent_t exp_q [4][$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   last_acc;
    bit   stall_seen;
    int   seq;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [63:0] all_outs();
        return {bus.wr0_en, bus.wr0_addr, bus.wr0_data, bus.done0_vld, bus.done0_idx,
                bus.wr1_en, bus.wr1_addr, bus.wr1_data, bus.done1_vld, bus.done1_idx,
                bus.stall_out};
    endfunction

    function automatic ent_t in_ent(input int ch);
        return {bus.ch_reg_wrt[ch], bus.ch_phy_addr[ch*PREG_W +: PREG_W],
                bus.ch_data[ch*DATA_W +: DATA_W], bus.ch_done_idx[ch*ROB_W +: ROB_W]};
    endfunction

    task automatic clr_in();
        bus.ch_vld      = '0;
        bus.ch_reg_wrt  = '0;
        bus.ch_phy_addr = '0;
        bus.ch_data     = '0;
        bus.ch_done_idx = '0;
    endtask

    task automatic set_ch(input int ch, input logic wrt, input logic [PREG_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input logic [ROB_W-1:0] idx);
        bus.ch_vld[ch]                        = 1'b1;
        bus.ch_reg_wrt[ch]                    = wrt;
        bus.ch_phy_addr[ch*PREG_W +: PREG_W]  = addr;
        bus.ch_data[ch*DATA_W +: DATA_W]      = data;
        bus.ch_done_idx[ch*ROB_W +: ROB_W]    = idx;
    endtask

    task automatic set_rand(input int ch);
        set_ch(ch, 1'($urandom), 6'($urandom), {4'(ch), 12'($urandom)}, {2'(ch), 4'(seq)});
        seq++;
    endtask

    // One clock: the inputs presented now are accepted iff no reset, flush or stall.
    task automatic tick();
        bit acc  = !rst && !flush && !bus.stall_out;
        bit wipe = rst || flush;
        if (acc) begin
            for (int c = 0; c < 4; c++)
                if (bus.ch_vld[c]) exp_q[c].push_back(in_ent(c));
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        if (wipe) begin
            for (int c = 0; c < 4; c++) exp_q[c].delete();
        end
    endtask

    task automatic slot_chk(input int s, input logic v, input logic en, input logic [PREG_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [ROB_W-1:0] i);
        int tag;
        ent_t e;
        if (!v) begin
            check($sformatf("idle_slot%0d", s), {en, a, d, i}, '0);
        end else begin
            tag = int'(d[13:12]);
            if (exp_q[tag].size() == 0) begin
                check($sformatf("extra_out_slot%0d_ch%0d_qdepth", s, tag), exp_q[tag].size(), 1);
            end else begin
                e = exp_q[tag].pop_front();
                check($sformatf("out_slot%0d_ch%0d", s, tag), {en, a, d, i}, e);
            end
        end
    endtask

    always @(negedge clk) begin
        slot_chk(0, bus.done0_vld, bus.wr0_en, bus.wr0_addr, bus.wr0_data, bus.done0_idx);
        slot_chk(1, bus.done1_vld, bus.wr1_en, bus.wr1_addr, bus.wr1_data, bus.done1_idx);
        if (bus.done1_vld) check("slot1_without_slot0", bus.done0_vld, 1);
    end

    initial begin
        seq = 0;
        clr_in();

        // Reset with every channel valid: nothing out, no stall.
        rst = 1'b1;
        for (int c = 0; c < 4; c++) set_rand(c);
        tick();
        tick();
        check("reset_outs", all_outs(), '0);
        rst = 1'b0;
        clr_in();
        tick();
        check("post_reset_outs", all_outs(), '0);

        // Full burst with rr=0, twice: pairs (0,1) then (2,3), rr back at 0.
        for (int rep = 0; rep < 2; rep++) begin
            for (int c = 0; c < 4; c++) set_rand(c);
            tick();
            clr_in();
            repeat (LAT) tick();
            check($sformatf("burst%0d_pairA", rep),
                  {bus.done0_vld, bus.wr0_data[15:12], bus.done1_vld, bus.wr1_data[15:12]},
                  {1'b1, 4'd0, 1'b1, 4'd1});
            tick();
            check($sformatf("burst%0d_pairB", rep),
                  {bus.done0_vld, bus.wr0_data[15:12], bus.done1_vld, bus.wr1_data[15:12]},
                  {1'b1, 4'd2, 1'b1, 4'd3});
            tick();
        end

        // Single result on channel 1.
        set_ch(1, 1'b1, 6'h0A, 16'h1234, 6'd5);
        tick();
        clr_in();
        repeat (LAT) tick();
        check("single_wr0", {bus.wr0_en, bus.wr0_addr, bus.wr0_data}, {1'b1, 6'h0A, 16'h1234});
        check("single_done0", {bus.done0_vld, bus.done0_idx}, {1'b1, 6'd5});
        check("single_slot1_idle", {bus.done1_vld, bus.wr1_en}, 2'b00);
        tick();

        // Store on channel 3: completion without a register write.
        set_ch(3, 1'b0, 6'h11, 16'h3ABC, 6'd9);
        tick();
        clr_in();
        repeat (LAT) tick();
        check("store_done0", {bus.done0_vld, bus.done0_idx, bus.wr0_en}, {1'b1, 6'd9, 1'b0});
        tick();

        // Queue up three entries, then flush with inputs present.
        for (int c = 0; c < 4; c++) set_rand(c);
        tick();
        clr_in();
        set_rand(0);
        tick();
        flush = 1'b1;
        for (int c = 0; c < 4; c++) set_rand(c);
        tick();
        flush = 1'b0;
        clr_in();
        check("flush_outs", all_outs(), '0);
        repeat (5) tick();
        check("post_flush_outs", all_outs(), '0);

        // Saturating stream: hold inputs while stalled, new ones once accepted.
        stall_seen = 1'b0;
        last_acc   = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (last_acc) begin
                for (int c = 0; c < 4; c++) set_rand(c);
            end
            stall_seen |= bus.stall_out;
            tick();
        end
        clr_in();
        check("stall_seen", stall_seen, 1'b1);
        repeat (10) tick();
        check("drained_stall", bus.stall_out, 1'b0);
        for (int c = 0; c < 4; c++)
            check($sformatf("drained_ch%0d_left", c), exp_q[c].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
